// File: rtl/ahb_mtimer_if.sv
// ahb_mtimer_if: AHB-Lite slave bus with write/read checksum sideband
interface ahb_mtimer_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [6:0]  hwchecksum;
    logic        hready;
    logic [31:0] hrdata;
    logic [6:0]  hrchecksum;
    logic        hreadyout;
    logic        hresp;
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hwchecksum, hready,
        output hrdata, hrchecksum, hreadyout, hresp
    );
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hwchecksum, hready,
        input  hrdata, hrchecksum, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_mtimer.sv
// ahb_mtimer: memory-mapped 64-bit mtime/mtimecmp machine timer on AHB-Lite
module ahb_mtimer #(
    parameter bit         ENABLE_RST = 1'b1,
    parameter logic [7:0] PRESC_RST  = 8'd0,
    parameter bit         CHECK_WCS  = 1'b1
) (
    input  logic         s_clk_i,
    input  logic         s_reset_i,
    ahb_mtimer_if.slave  s,
    output logic         s_int_mtip_o
);
    // SEC-DED: low six bits are the XOR of the Hamming positions of set data bits
    function automatic logic [6:0] ecc(input logic [31:0] d);
        logic [5:0] syn;
        int k;
        syn = '0;
        k = 0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[k[4:0]]) syn = syn ^ 6'(p);
                k = k + 1;
            end
        end
        return {^d ^ ^syn, syn};
    endfunction

    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  presc_q, presc_d, cnt_q, cnt_d;
    logic [2:0]  off_q, off_d;
    logic        en_q, en_d, mtip_q, mtip_d;
    logic        act_q, act_d, wr_q, wr_d, aerr_q, aerr_d, err2_q, err2_d;
    logic        err, rd, we, tick;
    logic [31:0] rdata;
    logic        unused;

    assign unused = ^{s.haddr[31:5], s.htrans[0]};
    assign s_int_mtip_o = mtip_q;

    always_comb begin
        err = act_q && (aerr_q || (wr_q && CHECK_WCS && s.hwchecksum != ecc(s.hwdata)));
        rd = act_q && !wr_q && !err;
        we = act_q && wr_q && !err;
        rdata = !rd          ? 32'h0 :
                off_q == 3'd0 ? mtime_q[31:0] :
                off_q == 3'd1 ? shadow_q :
                off_q == 3'd2 ? mtimecmp_q[31:0] :
                off_q == 3'd3 ? mtimecmp_q[63:32] : {16'h0, presc_q, 7'h0, en_q};
        s.hrdata = rdata;
        s.hrchecksum = ecc(rdata);
        s.hreadyout = !err;
        s.hresp = err || err2_q;
        tick = en_q && cnt_q == presc_q;
        cnt_d = tick ? 8'd0 : cnt_q + 8'(en_q);
        mtime_d = mtime_q + 64'(tick);
        mtimecmp_d = mtimecmp_q;
        shadow_d = shadow_q;
        en_d = en_q;
        presc_d = presc_q;
        // a bus write to either mtime half overrides (and drops) this cycle's tick
        if (we && off_q == 3'd0) mtime_d = {mtime_q[63:32], s.hwdata};
        if (we && off_q == 3'd1) begin
            mtime_d = {s.hwdata, mtime_q[31:0]};
            shadow_d = s.hwdata;
        end
        if (we && off_q == 3'd2) mtimecmp_d[31:0] = s.hwdata;
        if (we && off_q == 3'd3) mtimecmp_d[63:32] = s.hwdata;
        if (we && off_q == 3'd4) begin
            en_d = s.hwdata[0];
            presc_d = s.hwdata[15:8];
            cnt_d = 8'd0;
        end
        if (rd && off_q == 3'd0) shadow_d = mtime_q[63:32];
        mtip_d = mtime_q >= mtimecmp_q;
        act_d = s.hsel && s.htrans[1] && s.hready && !err;
        wr_d = s.hwrite;
        off_d = s.haddr[4:2];
        aerr_d = s.hsize != 3'b010 || s.haddr[1:0] != 2'b00 || s.haddr[4:2] > 3'd4;
        err2_d = err;
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            mtime_q <= '0;
            mtimecmp_q <= '1;
            shadow_q <= '0;
            en_q <= ENABLE_RST;
            presc_q <= PRESC_RST;
            cnt_q <= '0;
            mtip_q <= 1'b0;
            act_q <= 1'b0;
            wr_q <= 1'b0;
            off_q <= '0;
            aerr_q <= 1'b0;
            err2_q <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q <= shadow_d;
            en_q <= en_d;
            presc_q <= presc_d;
            cnt_q <= cnt_d;
            mtip_q <= mtip_d;
            act_q <= act_d;
            wr_q <= wr_d;
            off_q <= off_d;
            aerr_q <= aerr_d;
            err2_q <= err2_d;
        end
    end
endmodule

// File: tb/tb_ahb_mtimer.sv
// tb_ahb_mtimer: directed bench with a time-based mtime model and per-cycle output compare
module tb_ahb_mtimer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_mtimer_if bus();
    ahb_mtimer_if nbus();
    logic mtip, nmtip;

    assign bus.hready = bus.hreadyout;
    assign nbus.hready = nbus.hreadyout;
    assign nbus.hsel = bus.hsel;
    assign nbus.haddr = bus.haddr;
    assign nbus.htrans = bus.htrans;
    assign nbus.hwrite = bus.hwrite;
    assign nbus.hsize = bus.hsize;
    assign nbus.hwdata = bus.hwdata;
    assign nbus.hwchecksum = bus.hwchecksum;

    ahb_mtimer #(.ENABLE_RST(1'b1), .PRESC_RST(8'd0), .CHECK_WCS(1'b1)) dut (
        .s_clk_i(clk), .s_reset_i(rst), .s(bus), .s_int_mtip_o(mtip));
    ahb_mtimer #(.ENABLE_RST(1'b1), .PRESC_RST(8'd0), .CHECK_WCS(1'b0)) dut_nc (
        .s_clk_i(clk), .s_reset_i(rst), .s(nbus), .s_int_mtip_o(nmtip));

    int ecount = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    logic exp_rdy = 1'b1, exp_resp = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic prev_ge = 1'b0;

    // mtime(e) = base + ticks since anchor up to e, minus ticks up to the base edge
    logic [63:0] m_bval = 64'h0;
    logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    int m_bedge = 0, m_anchor = 0;
    logic m_en = 1'b1;
    logic [7:0] m_presc = 8'd0;
    logic [31:0] m_shadow = 32'h0;

    logic [31:0] rd_got, nc_rd_got;
    logic rdy_got, resp_got, nc_rdy_got, nc_resp_got;

    always @(posedge clk) ecount <= ecount + 1;

    function automatic logic [6:0] becc(input logic [31:0] d);
        logic [63:0] cw;
        logic [6:0] r;
        int k;
        cw = '0;
        r = '0;
        k = 0;
        for (int p = 1; p <= 38; p++)
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
                cw[p[5:0]] = d[k[4:0]];
                k = k + 1;
            end
        for (int i = 0; i < 6; i++)
            for (int p = 1; p <= 38; p++)
                if (((p >> i) & 1) == 1) r[i[2:0]] = r[i[2:0]] ^ cw[p[5:0]];
        r[6] = ^cw ^ ^r[5:0];
        return r;
    endfunction

    function automatic logic [63:0] mval(input int e);
        int t, tb;
        t = m_en ? (e - m_anchor) / (int'(m_presc) + 1) : 0;
        tb = m_en ? (m_bedge - m_anchor) / (int'(m_presc) + 1) : 0;
        return m_bval + 64'(t - tb);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        logic [63:0] v;
        v = mval(ecount);
        return off == 3'd0 ? v[31:0] : off == 3'd1 ? m_shadow :
               off == 3'd2 ? m_cmp[31:0] : off == 3'd3 ? m_cmp[63:32] :
               {16'h0, m_presc, 7'h0, m_en};
    endfunction

    task automatic m_write(input logic [2:0] off, input logic [31:0] d);
        logic [63:0] v;
        v = mval(ecount - 1);
        if (off == 3'd0) begin m_bval = {v[63:32], d}; m_bedge = ecount; end
        if (off == 3'd1) begin m_bval = {d, v[31:0]}; m_bedge = ecount; m_shadow = d; end
        if (off == 3'd2) m_cmp[31:0] = d;
        if (off == 3'd3) m_cmp[63:32] = d;
        if (off == 3'd4) begin
            m_bval = mval(ecount);
            m_bedge = ecount;
            m_anchor = ecount;
            m_en = d[0];
            m_presc = d[15:8];
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        chk("hreadyout", 64'(bus.hreadyout), 64'(exp_rdy));
        chk("hresp", 64'(bus.hresp), 64'(exp_resp));
        chk("hrdata", 64'(bus.hrdata), 64'(exp_rdata));
        chk("hrchecksum", 64'(bus.hrchecksum), 64'(becc(exp_rdata)));
        chk("mtip", 64'(mtip), 64'(prev_ge));
        prev_ge <= mval(ecount) >= m_cmp;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_rdy = 1'b1;
        exp_resp = 1'b0;
        exp_rdata = 32'h0;
    endtask

    task automatic sample();
        @(negedge clk);
        rd_got = bus.hrdata;
        rdy_got = bus.hreadyout;
        resp_got = bus.hresp;
        nc_rd_got = nbus.hrdata;
        nc_rdy_got = nbus.hreadyout;
        nc_resp_got = nbus.hresp;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [6:0] flip);
        logic e;
        logic [2:0] off;
        logic [63:0] v;
        off = a[4:2];
        e = sz != 3'b010 || a[1:0] != 2'b00 || off > 3'd4 || (wr && flip != 7'h0);
        exp_idle();
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = a; bus.hwrite = wr; bus.hsize = sz;
        cyc();
        bus.hwdata = wd;
        bus.hwchecksum = becc(wd) ^ flip;
        if (e) begin
            // a write to MTIMECMP_LO offered while the slave stalls must be dropped
            exp_rdy = 1'b0; exp_resp = 1'b1;
            bus.haddr = 32'h8; bus.hwrite = 1'b1; bus.hsize = 3'b010;
        end else begin
            bus.hsel = 1'b0; bus.htrans = 2'b00;
            if (!wr) begin
                exp_rdata = m_read(off);
                v = mval(ecount);
                if (off == 3'd0) m_shadow = v[63:32];
            end
        end
        sample();
        if (e) begin
            bus.hsel = 1'b0; bus.htrans = 2'b00;
            exp_rdy = 1'b1; exp_resp = 1'b1; exp_rdata = 32'h0;
            cyc();
        end else if (wr) m_write(off, wd);
        exp_idle();
    endtask

    task automatic wr_rd(input logic [31:0] a, input logic [31:0] wd);
        logic [63:0] v;
        exp_idle();
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = a; bus.hwrite = 1'b1; bus.hsize = 3'b010;
        cyc();
        bus.hwdata = wd; bus.hwchecksum = becc(wd);
        bus.htrans = 2'b11; bus.hwrite = 1'b0;
        cyc();
        m_write(a[4:2], wd);
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        exp_rdata = m_read(a[4:2]);
        v = mval(ecount);
        if (a[4:2] == 3'd0) m_shadow = v[63:32];
        sample();
        exp_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, w;
        logic [31:0] a, lo;
        bus.hsel = 1'b0; bus.haddr = 32'h0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
        bus.hsize = 3'b010; bus.hwdata = 32'h0; bus.hwchecksum = 7'h0;
        repeat (3) cyc();
        chk("ecc_pin_zero", 64'(becc(32'h0)), 64'h00);
        chk("ecc_pin_one", 64'(becc(32'h1)), 64'h43);
        chk("rst_hreadyout", 64'(bus.hreadyout), 64'h1);
        chk("rst_hresp", 64'(bus.hresp), 64'h0);
        chk("rst_hrdata", 64'(bus.hrdata), 64'h0);
        chk("rst_hrchecksum", 64'(bus.hrchecksum), 64'h00);
        chk("rst_mtip", 64'(mtip), 64'h0);
        chk("rst_mtip_nc", 64'(nmtip), 64'h0);
        rst = 1'b0;
        rel = ecount;
        m_anchor = ecount;
        m_bedge = ecount;
        chk_on = 1'b1;
        repeat (10) cyc();
        xfer(1'b0, 32'h0, 3'b010, 32'h0, 7'h0);
        chk("mtime_after_10", 64'(rd_got), 64'd11);

        xfer(1'b1, 32'h8, 3'b010, 32'd20, 7'h0);
        xfer(1'b1, 32'hC, 3'b010, 32'd0, 7'h0);
        for (int i = 0; i < 60; i++) begin
            if (mtip) break;
            cyc();
        end
        chk("mtip_rise_edge", 64'(ecount - rel), 64'd21);
        xfer(1'b1, 32'hC, 3'b010, 32'd1, 7'h0);
        w = ecount;
        for (int i = 0; i < 10; i++) begin
            if (!mtip) break;
            cyc();
        end
        chk("mtip_fall_latency", 64'(ecount - w), 64'd1);

        xfer(1'b1, 32'h10, 3'b010, 32'h0000_0301, 7'h0);
        xfer(1'b0, 32'h10, 3'b010, 32'h0, 7'h0);
        chk("ctrl_readback", 64'(rd_got), 64'h301);
        xfer(1'b0, 32'h0, 3'b010, 32'h0, 7'h0);
        a = rd_got;
        repeat (6) cyc();
        xfer(1'b0, 32'h0, 3'b010, 32'h0, 7'h0);
        chk("presc3_ticks_in_8", 64'(rd_got - a), 64'd2);
        xfer(1'b1, 32'h10, 3'b010, 32'h0000_0300, 7'h0);
        xfer(1'b0, 32'h0, 3'b010, 32'h0, 7'h0);
        a = rd_got;
        repeat (50) cyc();
        xfer(1'b0, 32'h0, 3'b010, 32'h0, 7'h0);
        chk("disabled_frozen", 64'(rd_got - a), 64'd0);

        xfer(1'b1, 32'h10, 3'b010, 32'h0000_0001, 7'h0);
        xfer(1'b1, 32'h4, 3'b010, 32'h0, 7'h0);
        xfer(1'b1, 32'h0, 3'b010, 32'hFFFF_FFFF, 7'h0);
        xfer(1'b0, 32'h0, 3'b010, 32'h0, 7'h0);
        lo = rd_got;
        xfer(1'b0, 32'h4, 3'b010, 32'h0, 7'h0);
        chk("wrap_lo", 64'(lo), 64'd0);
        chk("wrap_hi_shadow", 64'(rd_got), 64'd1);

        xfer(1'b0, 32'h14, 3'b010, 32'h0, 7'h0);
        chk("err_unmapped_c1", {62'h0, rdy_got, resp_got}, 64'h1);
        xfer(1'b0, 32'h0, 3'b001, 32'h0, 7'h0);
        chk("err_halfword_c1", {62'h0, rdy_got, resp_got}, 64'h1);
        xfer(1'b0, 32'h2, 3'b010, 32'h0, 7'h0);
        chk("err_misalign_c1", {62'h0, rdy_got, resp_got}, 64'h1);
        xfer(1'b0, 32'h8, 3'b010, 32'h0, 7'h0);
        chk("cmp_lo_after_errors", 64'(rd_got), 64'd20);

        xfer(1'b1, 32'h8, 3'b010, 32'hCAFE_F00D, 7'h04);
        chk("wcs_main_err", {62'h0, rdy_got, resp_got}, 64'h1);
        chk("wcs_nc_okay", {62'h0, nc_rdy_got, nc_resp_got}, 64'h2);
        xfer(1'b0, 32'h8, 3'b010, 32'h0, 7'h0);
        chk("wcs_main_kept", 64'(rd_got), 64'd20);
        chk("wcs_nc_written", 64'(nc_rd_got), 64'hCAFE_F00D);

        wr_rd(32'h8, 32'h0000_5555);
        chk("b2b_cmp_lo", 64'(rd_got), 64'h5555);
        wr_rd(32'h0, 32'h0000_0100);
        chk("b2b_mtime_lo", 64'(rd_got), 64'h100);
        cyc();

        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h14; bus.hwrite = 1'b0;
        cyc();
        chk_on = 1'b0;
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        #1;
        chk("midrst_err_active", 64'(bus.hreadyout), 64'h0);
        rst = 1'b1;
        #1;
        chk("midrst_hreadyout", 64'(bus.hreadyout), 64'h1);
        chk("midrst_hresp", 64'(bus.hresp), 64'h0);
        chk("midrst_hrdata", 64'(bus.hrdata), 64'h0);
        chk("midrst_mtip", 64'(mtip), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
